vga_output_timing: RTL and testbench

- Display-side consumer of the pixel pipeline's colour/stall interface.
- Generates full SVGA raster timing (visible, front porch, sync, back porch) and drives vg__stall, so the pipeline advances only on visible pixels.
- Registers colour and syncs to the VGA pins.
- Default mode: 800x600@72 Hz from a 50 MHz pixel clock.

---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_sync_counter.sv | 50 +++++
 rtl/vga_output_timing.sv | 152 +++++++++++++++
 tb/tb_vga_output_timing.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared raster constants and FSM encoding for the display output stage and the pixel pipeline.
// Default mode is 800x600@72 Hz from a 50 MHz pixel clock.
package vga_pkg;

    localparam int H_VISIBLE  = 800;
    localparam int H_FRONT    = 56;
    localparam int H_SYNC     = 120;
    localparam int H_BACK     = 64;
    localparam int V_VISIBLE  = 600;
    localparam int V_FRONT    = 37;
    localparam int V_SYNC     = 6;
    localparam int V_BACK     = 23;

    localparam int H_TOTAL    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int WIDTHBITS  = 11;
    localparam int HEIGHTBITS = 10;
    localparam int COLORBITS  = 8;

    typedef enum logic {
        PREFILL = 1'b0,
        RUN     = 1'b1
    } vga_state_t;

endpackage

// File: rtl/vga_sync_counter.sv
// Single-axis raster counter: wraps at the axis total, carries out on wrap, decodes visible/sync windows.
// Count updates one cycle after en; visible_next is the decode of the value about to be loaded.
module vga_sync_counter
    import vga_pkg::*;
#(
    parameter int VISIBLE = 800,
    parameter int FRONT   = 56,
    parameter int SYNC    = 120,
    parameter int BACK    = 64,
    parameter int WIDTH   = 11
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             carry,
    output logic             visible,
    output logic             visible_next,
    output logic             sync_on
);

    localparam int TOTAL = VISIBLE + FRONT + SYNC + BACK;
    localparam logic [WIDTH-1:0] LAST    = WIDTH'(TOTAL - 1);
    localparam logic [WIDTH-1:0] VIS_END = WIDTH'(VISIBLE);
    localparam logic [WIDTH-1:0] SYNC_LO = WIDTH'(VISIBLE + FRONT);
    localparam logic [WIDTH-1:0] SYNC_HI = WIDTH'(VISIBLE + FRONT + SYNC - 1);

    logic [WIDTH-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt;
        if (en) begin
            cnt_next = (cnt == LAST) ? '0 : cnt + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

    assign carry        = en && (cnt == LAST);
    assign visible      = (cnt < VIS_END);
    assign visible_next = (cnt_next < VIS_END);
    assign sync_on      = (cnt >= SYNC_LO) && (cnt <= SYNC_HI);

endmodule

// File: rtl/vga_output_timing.sv
// SVGA raster generator driving vg__stall to the pixel pipeline; colour/syncs registered, 1 cycle after counters.
// Pipeline frozen (vg__stall=1) in reset and blanking. VGA_OUTPUT_BORDER_EN adds an all-ones alignment border.
module vga_output_timing
    import vga_pkg::*;
#(
    parameter int H_VISIBLE  = vga_pkg::H_VISIBLE,
    parameter int H_FRONT    = vga_pkg::H_FRONT,
    parameter int H_SYNC     = vga_pkg::H_SYNC,
    parameter int H_BACK     = vga_pkg::H_BACK,
    parameter int V_VISIBLE  = vga_pkg::V_VISIBLE,
    parameter int V_FRONT    = vga_pkg::V_FRONT,
    parameter int V_SYNC     = vga_pkg::V_SYNC,
    parameter int V_BACK     = vga_pkg::V_BACK,
    parameter bit HSYNC_POL  = 1'b1,
    parameter bit VSYNC_POL  = 1'b1,
    parameter int WIDTHBITS  = vga_pkg::WIDTHBITS,
    parameter int HEIGHTBITS = vga_pkg::HEIGHTBITS,
    parameter int COLORBITS  = vga_pkg::COLORBITS,
    parameter int PIPE_DEPTH = 1
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic [COLORBITS-1:0] vg__color,
    output logic                 vg__stall,
    output logic [COLORBITS-1:0] vga_color,
    output logic                 vga_hsync,
    output logic                 vga_vsync,
    output logic                 vga_frame_start
);

    localparam int PW = $clog2(PIPE_DEPTH + 2);
    localparam logic [PW-1:0] PREFILL_LAST = PW'(PIPE_DEPTH);

    vga_state_t state, state_next;
    logic [PW-1:0] pre_cnt, pre_cnt_next;
    logic stall_next;
    logic run;

    logic [WIDTHBITS-1:0]  hcnt;
    logic [HEIGHTBITS-1:0] vcnt;
    logic h_carry, h_vis, h_vis_next, h_sync_on;
    logic v_carry_unused, v_vis, v_vis_next, v_sync_on;
    logic visible;
    logic [COLORBITS-1:0] pix;

    assign run     = (state == RUN);
    assign visible = h_vis && v_vis;

    vga_sync_counter #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK),
        .WIDTH   (WIDTHBITS)
    ) u_hcnt (
        .clk          (clk),
        .rst_b        (rst_b),
        .en           (run),
        .cnt          (hcnt),
        .carry        (h_carry),
        .visible      (h_vis),
        .visible_next (h_vis_next),
        .sync_on      (h_sync_on)
    );

    vga_sync_counter #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK),
        .WIDTH   (HEIGHTBITS)
    ) u_vcnt (
        .clk          (clk),
        .rst_b        (rst_b),
        .en           (h_carry),
        .cnt          (vcnt),
        .carry        (v_carry_unused),
        .visible      (v_vis),
        .visible_next (v_vis_next),
        .sync_on      (v_sync_on)
    );

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state     <= PREFILL;
            pre_cnt   <= '0;
            vg__stall <= 1'b1;
        end else begin
            state     <= state_next;
            pre_cnt   <= pre_cnt_next;
            vg__stall <= stall_next;
        end
    end

    // Stall is registered from next-state counters so it lines up with the visible decode of the cycle it applies to.
    always_comb begin
        state_next   = state;
        pre_cnt_next = pre_cnt;
        stall_next   = 1'b1;
        case (state)
            PREFILL: begin
                if (pre_cnt == PREFILL_LAST) begin
                    state_next = RUN;
                    stall_next = !(h_vis_next && v_vis_next);
                end else begin
                    pre_cnt_next = pre_cnt + PW'(1);
                    stall_next   = 1'b0;
                end
            end
            RUN: begin
                stall_next = !(h_vis_next && v_vis_next);
            end
            default: begin
                state_next = PREFILL;
            end
        endcase
    end

`ifdef VGA_OUTPUT_BORDER_EN
    localparam logic [WIDTHBITS-1:0]  H_EDGE = WIDTHBITS'(H_VISIBLE - 1);
    localparam logic [HEIGHTBITS-1:0] V_EDGE = HEIGHTBITS'(V_VISIBLE - 1);
    logic border;
    assign border = (hcnt == '0) || (hcnt == H_EDGE) || (vcnt == '0) || (vcnt == V_EDGE);
`endif

    always_comb begin
        pix = '0;
        if (run && visible) begin
            pix = vg__color;
`ifdef VGA_OUTPUT_BORDER_EN
            if (border) begin
                pix = '1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            vga_color       <= '0;
            vga_hsync       <= !HSYNC_POL;
            vga_vsync       <= !VSYNC_POL;
            vga_frame_start <= 1'b0;
        end else begin
            vga_color       <= pix;
            vga_hsync       <= (run && h_sync_on) ? HSYNC_POL : !HSYNC_POL;
            vga_vsync       <= (run && v_sync_on) ? VSYNC_POL : !VSYNC_POL;
            vga_frame_start <= run && (hcnt == '0) && (vcnt == '0);
        end
    end

endmodule

// File: tb/tb_vga_output_timing.sv
// Bench for vga_output_timing on a shrunken 15x8 raster with a PIPE_DEPTH=1 pixel-pipeline model.
// Honours VGA_OUTPUT_BORDER_EN for expected colours.
module tb_vga_output_timing;

    localparam int HV = 8, HF = 2, HS = 3, HB = 2;
    localparam int VV = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int PD = 1;

    logic       clk = 1'b0;
    logic       rst_b = 1'b0;
    logic [7:0] vg__color = 8'h00;
    logic       vg__stall;
    logic [7:0] vga_color;
    logic       vga_hsync, vga_vsync, vga_frame_start;

    vga_output_timing #(
        .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
        .HSYNC_POL (1'b1), .VSYNC_POL (1'b1),
        .WIDTHBITS (4), .HEIGHTBITS (3), .COLORBITS (8), .PIPE_DEPTH (PD)
    ) dut (
        .clk             (clk),
        .rst_b           (rst_b),
        .vg__color       (vg__color),
        .vg__stall       (vg__stall),
        .vga_color       (vga_color),
        .vga_hsync       (vga_hsync),
        .vga_vsync       (vga_vsync),
        .vga_frame_start (vga_frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       stall;
        logic [7:0] color;
        logic       hs;
        logic       vs;
        logic       fs;
    } obs_t;

    typedef struct {
        int mode;
        int rst_at;
        int run_cycles;
        int exp_first_fs;
        int exp_period;
        int exp_ff;
    } phase_t;

    obs_t exp_q[$];
    int   fs_hist[$];
    logic stall_hist[512];
    int   checks = 0;
    int   failures = 0;
    int   k = 0;
    int   mode = 0;
    int   ff_cnt = 0;
    int   px = 0, py = 0;
    logic rst_s = 1'b0;
    logic stall_s = 1'b1;

    function automatic logic [7:0] src_pix(int m, int h, int v);
        case (m)
            0:       return 8'((h + 1) + (v * 16));
            1:       return 8'hFF;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] exp_pix(int m, int h, int v);
`ifdef VGA_OUTPUT_BORDER_EN
        if (h == 0 || h == HV - 1 || v == 0 || v == VV - 1) return 8'hFF;
`endif
        return src_pix(m, h, v);
    endfunction

    // kk = edges since the first edge that sampled rst_b high (0 while in reset).
    function automatic obs_t expect_at(int kk, int m);
        obs_t e;
        int n, p, h, v, nh, nv;
        e = {1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
        if (kk >= 1) begin
            n = kk - PD - 1;
            if (n < 0) begin
                e.stall = 1'b0;
            end else begin
                nh = n % HT;
                nv = (n / HT) % VT;
                e.stall = !(nh < HV && nv < VV);
            end
            p = n - 1;
            if (p >= 0) begin
                h = p % HT;
                v = (p / HT) % VT;
                e.color = (h < HV && v < VV) ? exp_pix(m, h, v) : 8'h00;
                e.hs    = (h >= HV + HF) && (h < HV + HF + HS);
                e.vs    = (v >= VV + VF) && (v < VV + VF + VS);
                e.fs    = (h == 0) && (v == 0);
            end
        end
        return e;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Pixel pipeline model plus scoreboard push, just after each active edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            k = rst_s ? k + 1 : 0;
            if (!rst_s) begin
                px = 0;
                py = 0;
                vg__color = 8'h00;
            end else if (!stall_s) begin
                vg__color = src_pix(mode, px, py);
                if (px == HV - 1) begin
                    px = 0;
                    py = (py == VV - 1) ? 0 : py + 1;
                end else begin
                    px++;
                end
            end
            exp_q.push_back(expect_at(k, mode));
        end
    end

    always @(negedge clk) begin
        obs_t got, e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = {vg__stall, vga_color, vga_hsync, vga_vsync, vga_frame_start};
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL raster k=%0d got stall=%b color=%h hs=%b vs=%b fs=%b exp stall=%b color=%h hs=%b vs=%b fs=%b",
                         k, got.stall, got.color, got.hs, got.vs, got.fs,
                         e.stall, e.color, e.hs, e.vs, e.fs);
            end
        end
        if (vga_frame_start === 1'b1) fs_hist.push_back(k);
        if (k < 512) stall_hist[k] = vg__stall;
        if (k >= 3 && k <= 122 && vga_color === 8'hFF) ff_cnt++;
        rst_s   = rst_b;
        stall_s = vg__stall;
    end

    initial begin
        phase_t ph[4];
        int bord;
        int low;
        bit hit;
`ifdef VGA_OUTPUT_BORDER_EN
        bord = 20;
`else
        bord = 0;
`endif
        ph[0] = '{0, 0,  300, 3, 120, bord};
        ph[1] = '{1, 0,  260, 3, 120, 32};
        ph[2] = '{2, 0,  260, 3, 120, bord};
        ph[3] = '{0, 36, 300, 3, 120, bord};

        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #2;
            rst_b = 1'b0;
            mode  = ph[i].mode;
            repeat (3) @(posedge clk);
            #2;
            rst_b = 1'b1;
            fs_hist.delete();
            ff_cnt = 0;

            if (ph[i].rst_at > 0) begin
                hit = 1'b0;
                for (int c = 0; c < 2000 && !hit; c++) begin
                    @(posedge clk);
                    #2;
                    if (k == ph[i].rst_at) hit = 1'b1;
                end
                chk("mid_reset_reached", int'(hit), 1);
                rst_b = 1'b0;
                @(posedge clk);
                @(negedge clk);
                chk("mid_reset_outputs",
                    int'({vg__stall, vga_color, vga_hsync, vga_vsync, vga_frame_start}),
                    int'({1'b1, 8'h00, 1'b0, 1'b0, 1'b0}));
                repeat (2) @(posedge clk);
                #2;
                rst_b = 1'b1;
                fs_hist.delete();
                ff_cnt = 0;
            end

            repeat (ph[i].run_cycles) @(posedge clk);
            #2;

            chk("fs_seen_twice", int'(fs_hist.size() >= 2), 1);
            if (fs_hist.size() >= 2) begin
                chk("fs_first_after_release", fs_hist[0], ph[i].exp_first_fs);
                chk("fs_period", fs_hist[1] - fs_hist[0], ph[i].exp_period);
            end
            chk("ff_pixels_in_frame", ff_cnt, ph[i].exp_ff);

            if (i == 0) begin
                chk("stall_in_reset", int'(stall_hist[0]), 1);
                chk("stall_prefill", int'(stall_hist[1]), 0);
                low = 0;
                for (int j = 2; j <= 16; j++) low += int'(!stall_hist[j]);
                chk("line0_stall_low_cycles", low, 8);
                chk("line0_last_visible", int'(stall_hist[9]), 0);
                chk("line0_first_blank", int'(stall_hist[10]), 1);
                chk("line1_first_visible", int'(stall_hist[17]), 0);
                low = 0;
                for (int j = 32; j <= 46; j++) low += int'(!stall_hist[j]);
                chk("line2_stall_low_cycles", low, 8);
                low = 0;
                for (int j = 62; j <= 76; j++) low += int'(!stall_hist[j]);
                chk("vblank_line_stall_low", low, 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
